// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// opcode values, datapath select encodings and the legal R-type funct set.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 5;

    localparam logic [OPCODE_W-1:0] OP_ALUI0     = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ALUI1     = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_LOAD      = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_STORE     = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_BRANCH_LO = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_CALL      = 6'd14;
    localparam logic [OPCODE_W-1:0] OP_BRANCH_HI = 6'd15;
    localparam logic [OPCODE_W-1:0] OP_RTYPE     = 6'd32;

    localparam logic [1:0] ALUSRC_REG   = 2'd0;
    localparam logic [1:0] ALUSRC_IMM   = 2'd1;
    localparam logic [1:0] ALUSRC_SHAMT = 2'd2;
    localparam logic [1:0] ALUSRC_PCREL = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    localparam logic [1:0] DST_RD   = 2'd0;
    localparam logic [1:0] DST_RT   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;

    // One bit per funct value: {0,1,2,3,4,5,7,12,13,15} are implemented.
    localparam logic [31:0] LEGAL_FUNCT = 32'h0000_B0BF;

    typedef struct packed {
        logic [2:0] alu_ctl;
        logic [1:0] alu_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [3:0] flag;
        logic       branch;
        logic       mem_access;
        logic       store;
        logic       writeback;
    } decode_t;

    function automatic logic funct_is_legal(input logic [FUNCT_W-1:0] funct);
        return LEGAL_FUNCT[funct];
    endfunction

    function automatic logic funct_uses_shamt(input logic [FUNCT_W-1:0] funct);
        return (funct == 5'd4) || (funct == 5'd5) || (funct == 5'd7);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode/funct decoder; the FSM latches its result in DECODE.
module control_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output decode_t             dec,
    output logic                illegal
);

    always_comb begin
        dec            = '0;
        dec.alu_src    = ALUSRC_REG;
        dec.mem_to_reg = WB_ALU;
        dec.reg_dst    = DST_RD;
        illegal        = 1'b0;

        if (opcode == OP_RTYPE) begin
            dec.alu_ctl   = funct[2:0];
            dec.alu_src   = funct_uses_shamt(funct) ? ALUSRC_SHAMT : ALUSRC_REG;
            dec.writeback = 1'b1;
            illegal       = !funct_is_legal(funct);
        end else if (opcode == OP_ALUI0 || opcode == OP_ALUI1) begin
            dec.alu_ctl   = opcode[2:0];
            dec.alu_src   = ALUSRC_IMM;
            dec.writeback = 1'b1;
        end else if (opcode == OP_LOAD) begin
            dec.alu_src    = ALUSRC_IMM;
            dec.mem_to_reg = WB_MEM;
            dec.reg_dst    = DST_RT;
            dec.mem_access = 1'b1;
            dec.writeback  = 1'b1;
        end else if (opcode == OP_STORE) begin
            dec.alu_src    = ALUSRC_IMM;
            dec.mem_access = 1'b1;
            dec.store      = 1'b1;
        end else if (opcode >= OP_BRANCH_LO && opcode <= OP_BRANCH_HI) begin
            // Calls share the branch encoding space and add a link writeback.
            dec.branch  = 1'b1;
            dec.flag    = opcode[3:0];
            dec.alu_src = (opcode == 6'd13 || opcode == 6'd15) ? ALUSRC_PCREL : ALUSRC_IMM;
            if (opcode == OP_CALL) begin
                dec.writeback  = 1'b1;
                dec.mem_to_reg = WB_LINK;
                dec.reg_dst    = DST_LINK;
            end
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle processor control FSM with memory timeout and trap handling.
// Datapath selects are registered in DECODE; only IRWrite/PCWrite/MemWrite see mem_ready.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               mem_ready,
    input  logic               trap_ack,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         ALUSource,
    output logic [1:0]         MemToReg,
    output logic [1:0]         RegDst,
    output logic [2:0]         AluControl,
    output logic [3:0]         FlagControl,
    output logic               BranchControl,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               illegal,
    output logic               bus_error,
    output logic [2:0]         state
);

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           cur_state;
    state_t           next_state;
    decode_t          dec;
    decode_t          ctl;
    logic             dec_illegal;
    logic [CNT_W-1:0] wait_cnt;
    logic             started;
    logic             waiting;
    logic             timed_out;
    logic             fetch_done;
    logic             set_illegal;
    logic             set_bus_error;
    logic             clear_flags;
    logic             unused_bits;

    assign unused_bits = ^instruction[INSTR_W-OPCODE_W-1:FUNCT_W];

    control_decoder u_decoder (
        .opcode  (instruction[INSTR_W-1 -: OPCODE_W]),
        .funct   (instruction[FUNCT_W-1:0]),
        .dec     (dec),
        .illegal (dec_illegal)
    );

    // A request that would wait its MEM_TIMEOUT-th cycle gives up, unless ready arrives then.
    assign waiting   = mem_req && !mem_ready;
    assign timed_out = waiting && (wait_cnt == CNT_LAST);

    always_comb begin
        next_state    = cur_state;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        clear_flags   = 1'b0;
        if (started) begin
            case (cur_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        next_state = ST_DECODE;
                    end else if (timed_out) begin
                        next_state    = ST_TRAP;
                        set_bus_error = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        next_state  = ST_TRAP;
                        set_illegal = 1'b1;
                    end else begin
                        next_state = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ctl.mem_access)     next_state = ST_MEM;
                    else if (ctl.writeback) next_state = ST_WB;
                    else                    next_state = ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        next_state = ctl.writeback ? ST_WB : ST_FETCH;
                    end else if (timed_out) begin
                        next_state    = ST_TRAP;
                        set_bus_error = 1'b1;
                    end
                end
                ST_WB: next_state = ST_FETCH;
                ST_TRAP: begin
                    if (trap_ack) begin
                        next_state  = ST_FETCH;
                        clear_flags = 1'b1;
                    end
                end
                default: next_state = ST_FETCH;
            endcase
        end
    end

    // 'started' holds the first fetch request off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            started   <= 1'b0;
            ctl       <= '0;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            started   <= 1'b1;
            cur_state <= next_state;
            if (cur_state == ST_DECODE) begin
                ctl <= dec_illegal ? '0 : dec;
            end
            if (next_state != cur_state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (clear_flags) begin
                illegal   <= 1'b0;
                bus_error <= 1'b0;
            end else begin
                if (set_illegal)   illegal   <= 1'b1;
                if (set_bus_error) bus_error <= 1'b1;
            end
        end
    end

    assign mem_req       = started && (cur_state == ST_FETCH || cur_state == ST_MEM);
    assign fetch_done    = started && (cur_state == ST_FETCH) && mem_ready;
    assign IRWrite       = fetch_done;
    assign PCWrite       = fetch_done;
    assign MemWrite      = started && (cur_state == ST_MEM) && ctl.store && mem_ready;
    assign BranchControl = (cur_state == ST_EXEC) && ctl.branch;
    assign FlagControl   = BranchControl ? ctl.flag : 4'd0;
    assign RegWrite      = (cur_state == ST_WB);
    assign ALUSource     = ctl.alu_src;
    assign MemToReg      = ctl.mem_to_reg;
    assign RegDst        = ctl.reg_dst;
    assign AluControl    = ctl.alu_ctl;
    assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: a per-instruction reference model queues the expected
// output vector for every cycle, and a negedge monitor compares the DUT against it.
module tb_multicycle_control_unit;
   import multicycle_control_unit_pkg::*;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        mem_ready;
   logic        trap_ack;
   logic        mem_req;
   logic        IRWrite;
   logic        PCWrite;
   logic [1:0]  ALUSource;
   logic [1:0]  MemToReg;
   logic [1:0]  RegDst;
   logic [2:0]  AluControl;
   logic [3:0]  FlagControl;
   logic        BranchControl;
   logic        MemWrite;
   logic        RegWrite;
   logic        illegal;
   logic        bus_error;
   logic [2:0]  state;

   multicycle_control_unit #(
      .INSTR_W     (32),
      .MEM_TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instruction   (instruction),
      .mem_ready     (mem_ready),
      .trap_ack      (trap_ack),
      .mem_req       (mem_req),
      .IRWrite       (IRWrite),
      .PCWrite       (PCWrite),
      .ALUSource     (ALUSource),
      .MemToReg      (MemToReg),
      .RegDst        (RegDst),
      .AluControl    (AluControl),
      .FlagControl   (FlagControl),
      .BranchControl (BranchControl),
      .MemWrite      (MemWrite),
      .RegWrite      (RegWrite),
      .illegal       (illegal),
      .bus_error     (bus_error),
      .state         (state)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       mem_write;
      logic       reg_write;
      logic [3:0] flag;
      logic       illegal;
      logic       bus_error;
      logic [1:0] alu_src;
      logic [1:0] m2r;
      logic [1:0] rdst;
      logic [2:0] alu_ctl;
   } obs_t;

   localparam int OW = $bits(obs_t);

   typedef struct packed {
      obs_t v;
      obs_t mask;
   } exp_t;

   // care = {alu_ctl, alu_src, m2r, rdst}: which selects the instruction defines.
   typedef struct packed {
      logic       legal;
      logic       is_mem;
      logic       is_store;
      logic       has_wb;
      logic       is_branch;
      logic [2:0] alu_ctl;
      logic [1:0] alu_src;
      logic [1:0] m2r;
      logic [1:0] rdst;
      logic [3:0] flag;
      logic [3:0] care;
   } ref_t;

   exp_t exp_q[$];
   int   n_compared = 0;
   int   n_failed   = 0;
   int   cyc        = 0;
   logic exp_ill;
   logic exp_be;
   int   legal_f[10] = '{0, 1, 2, 3, 4, 5, 7, 12, 13, 15};

   // Reference decoder mirroring the specification's decode table.
   function automatic ref_t ref_decode(input int op, input int fn);
      ref_t r;
      r = '0;
      if (op == 32) begin
         r.legal   = (fn inside {0, 1, 2, 3, 4, 5, 7, 12, 13, 15});
         r.alu_ctl = 3'(fn % 8);
         r.alu_src = (fn == 4 || fn == 5 || fn == 7) ? 2'd2 : 2'd0;
         r.has_wb  = 1'b1;
         r.care    = 4'b1111;
      end else if (op <= 1) begin
         r.legal   = 1'b1;
         r.alu_ctl = 3'(op);
         r.alu_src = 2'd1;
         r.has_wb  = 1'b1;
         r.care    = 4'b1111;
      end else if (op == 2) begin
         r.legal   = 1'b1;
         r.alu_src = 2'd1;
         r.m2r     = 2'd1;
         r.rdst    = 2'd1;
         r.is_mem  = 1'b1;
         r.has_wb  = 1'b1;
         r.care    = 4'b1111;
      end else if (op == 3) begin
         r.legal    = 1'b1;
         r.alu_src  = 2'd1;
         r.is_mem   = 1'b1;
         r.is_store = 1'b1;
         r.care     = 4'b1100;
      end else if (op <= 15) begin
         r.legal     = 1'b1;
         r.is_branch = 1'b1;
         r.flag      = 4'(op);
         r.alu_src   = (op == 13 || op == 15) ? 2'd3 : 2'd1;
         r.care      = 4'b0100;
         if (op == 14) begin
            r.has_wb = 1'b1;
            r.m2r    = 2'd2;
            r.rdst   = 2'd2;
            r.care   = 4'b0111;
         end
      end
      return r;
   endfunction

   function automatic exp_t base(input state_t st);
      exp_t e;
      e              = '0;
      e.v.state      = st;
      e.v.illegal    = exp_ill;
      e.v.bus_error  = exp_be;
      e.mask         = '1;
      e.mask.alu_src = '0;
      e.mask.m2r     = '0;
      e.mask.rdst    = '0;
      e.mask.alu_ctl = '0;
      return e;
   endfunction

   function automatic exp_t with_dp(input exp_t e_in, input ref_t r);
      exp_t e;
      e              = e_in;
      e.v.alu_ctl    = r.alu_ctl;
      e.v.alu_src    = r.alu_src;
      e.v.m2r        = r.m2r;
      e.v.rdst       = r.rdst;
      e.mask.alu_ctl = {3{r.care[3]}};
      e.mask.alu_src = {2{r.care[2]}};
      e.mask.m2r     = {2{r.care[1]}};
      e.mask.rdst    = {2{r.care[0]}};
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e         = '0;
      e.v.state = ST_FETCH;
      e.mask    = '1;
      return e;
   endfunction

   function automatic logic [31:0] make_instr(input int op, input int fn);
      logic [31:0] rnd;
      rnd = $urandom;
      return {op[5:0], rnd[20:0], fn[4:0]};
   endfunction

   function automatic logic rand_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic logic rand_ack();
      return ($urandom_range(0, 3) == 0);
   endfunction

   // Drives one cycle of inputs and queues the expected output vector for it.
   task automatic applyStimulus(input logic rdy, input logic ack, input logic rstn, input exp_t e);
      mem_ready = rdy;
      trap_ack  = ack;
      rst_n     = rstn;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Direct point check of a single observed value against its expectation.
   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] expected);
      n_compared++;
      if (got !== expected) begin
         n_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expected);
      end
   endtask

   // Holds TRAP until trap_ack, then expects sticky flags to clear.
   task automatic trap_phase(input int ack_wait);
      for (int i = 0; i <= ack_wait; i++) begin
         applyStimulus(rand_bit(), logic'(i == ack_wait), 1'b1, base(ST_TRAP));
      end
      exp_ill = 1'b0;
      exp_be  = 1'b0;
   endtask

   // Runs one instruction through the FSM with the given fetch/memory waits.
   task automatic run_instr(input int op, input int fn, input int fwait, input int mwait, input int ack_wait);
      ref_t r;
      exp_t e;
      logic rdy;
      r = ref_decode(op, fn);
      for (int w = 0; w <= fwait; w++) begin
         rdy = logic'(w == fwait);
         if (rdy) instruction = make_instr(op, fn);
         e            = base(ST_FETCH);
         e.v.mem_req  = 1'b1;
         e.v.ir_write = rdy;
         e.v.pc_write = rdy;
         applyStimulus(rdy, rand_ack(), 1'b1, e);
      end
      applyStimulus(rand_bit(), rand_ack(), 1'b1, base(ST_DECODE));
      if (!r.legal) begin
         exp_ill = 1'b1;
         trap_phase(ack_wait);
         return;
      end
      e          = with_dp(base(ST_EXEC), r);
      e.v.branch = r.is_branch;
      e.v.flag   = r.is_branch ? r.flag : 4'd0;
      applyStimulus(rand_bit(), rand_ack(), 1'b1, e);
      if (r.is_mem) begin
         for (int w = 0; w < TIMEOUT; w++) begin
            rdy           = logic'(w == mwait);
            e             = with_dp(base(ST_MEM), r);
            e.v.mem_req   = 1'b1;
            e.v.mem_write = r.is_store && rdy;
            applyStimulus(rdy, rand_ack(), 1'b1, e);
            if (rdy) break;
         end
         if (mwait >= TIMEOUT) begin
            checkOutput("expired wait state", 8'(state), 8'(ST_TRAP));
            checkOutput("expired wait bus_error", 8'(bus_error), 8'd1);
            checkOutput("expired wait MemWrite", 8'(MemWrite), 8'd0);
            checkOutput("expired wait RegWrite", 8'(RegWrite), 8'd0);
            exp_be = 1'b1;
            trap_phase(ack_wait);
            return;
         end
      end
      if (r.has_wb) begin
         e             = with_dp(base(ST_WB), r);
         e.v.reg_write = 1'b1;
         applyStimulus(rand_bit(), rand_ack(), 1'b1, e);
      end
   endtask

   // A load is cut off in its first MEM wait cycle; everything must drop at once.
   task automatic reset_during_load();
      ref_t r;
      exp_t e;
      r            = ref_decode(2, 0);
      instruction  = make_instr(2, 0);
      e            = base(ST_FETCH);
      e.v.mem_req  = 1'b1;
      e.v.ir_write = 1'b1;
      e.v.pc_write = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, e);
      applyStimulus(rand_bit(), 1'b0, 1'b1, base(ST_DECODE));
      applyStimulus(rand_bit(), 1'b0, 1'b1, with_dp(base(ST_EXEC), r));
      e           = with_dp(base(ST_MEM), r);
      e.v.mem_req = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, e);
      applyStimulus(rand_bit(), 1'b0, 1'b0, reset_exp());
      applyStimulus(rand_bit(), 1'b0, 1'b0, reset_exp());
      applyStimulus(rand_bit(), 1'b0, 1'b1, reset_exp());
      exp_ill = 1'b0;
      exp_be  = 1'b0;
   endtask

   obs_t          act;
   exp_t          cur;
   logic [OW-1:0] act_v;
   logic [OW-1:0] exp_v;
   logic [OW-1:0] mask_v;

   // Negedge monitor: pops the expected vector for this cycle and compares under mask.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur           = exp_q.pop_front();
         act.state     = state;
         act.mem_req   = mem_req;
         act.ir_write  = IRWrite;
         act.pc_write  = PCWrite;
         act.branch    = BranchControl;
         act.mem_write = MemWrite;
         act.reg_write = RegWrite;
         act.flag      = FlagControl;
         act.illegal   = illegal;
         act.bus_error = bus_error;
         act.alu_src   = ALUSource;
         act.m2r       = MemToReg;
         act.rdst      = RegDst;
         act.alu_ctl   = AluControl;
         mask_v        = cur.mask;
         act_v         = act;
         act_v         = act_v & mask_v;
         exp_v         = cur.v;
         exp_v         = exp_v & mask_v;
         n_compared++;
         if (act_v !== exp_v) begin
            n_failed++;
            $display("[TB] FAIL cycle%0d state%0d outputs: got %h, expected %h (mask %h)",
                     cyc, cur.v.state, act_v, exp_v, mask_v);
         end
         cyc++;
      end
   end

   function automatic int pick_op(output int fn);
      int sel;
      sel = int'($urandom_range(0, 9));
      fn  = int'($urandom_range(0, 31));
      if (sel < 5) return int'($urandom_range(0, 15));
      if (sel == 5) fn = legal_f[$urandom_range(0, 9)];
      if (sel <= 6) return 32;
      return int'($urandom_range(16, 63));
   endfunction

   // Main sequence: reset checks, directed instructions, then random traffic.
   initial begin
      int op;
      int fn;
      rst_n       = 1'b1;
      mem_ready   = 1'b0;
      trap_ack    = 1'b0;
      instruction = '0;
      exp_ill     = 1'b0;
      exp_be      = 1'b0;
      #1 rst_n    = 1'b0;
      #1;
      checkOutput("reset state", 8'(state), 8'(ST_FETCH));
      checkOutput("reset mem_req", 8'(mem_req), 8'd0);
      checkOutput("reset IRWrite", 8'(IRWrite), 8'd0);
      checkOutput("reset PCWrite", 8'(PCWrite), 8'd0);
      checkOutput("reset RegWrite", 8'(RegWrite), 8'd0);
      checkOutput("reset MemWrite", 8'(MemWrite), 8'd0);
      checkOutput("reset BranchControl", 8'(BranchControl), 8'd0);
      checkOutput("reset illegal", 8'(illegal), 8'd0);
      checkOutput("reset bus_error", 8'(bus_error), 8'd0);
      @(posedge clk);
      #1;
      applyStimulus(rand_bit(), 1'b0, 1'b0, reset_exp());
      applyStimulus(rand_bit(), 1'b1, 1'b0, reset_exp());
      applyStimulus(rand_bit(), 1'b0, 1'b1, reset_exp());

      run_instr(32, 0, 0, 0, 0);
      run_instr(2, 0, 1, 3, 0);
      run_instr(9, 3, 0, 0, 0);
      run_instr(14, 0, 2, 0, 0);
      run_instr(20, 1, 0, 0, 2);
      run_instr(3, 0, 0, 4, 1);
      run_instr(3, 0, 1, 3, 0);
      run_instr(2, 0, 0, 4, 0);
      run_instr(32, 6, 0, 0, 1);
      run_instr(32, 7, 0, 0, 0);
      run_instr(32, 15, 1, 0, 0);
      run_instr(13, 0, 0, 0, 0);
      run_instr(1, 0, 0, 0, 0);
      run_instr(0, 9, 3, 0, 0);
      run_instr(63, 0, 0, 0, 3);
      reset_during_load();

      for (int k = 0; k < 80; k++) begin
         op = pick_op(fn);
         run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)));
      end

      @(negedge clk);
      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
